// File: rtl/piece_move_sched_pkg.sv
// Shared types and key constants for the falling-piece move sequencer.
package piece_move_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_LEFT  = 3'd1,
    CMD_RIGHT = 3'd2,
    CMD_DOWN  = 3'd3,
    CMD_ROT   = 3'd4,
    CMD_LOCK  = 3'd5
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_LOCK_ISSUE,
    S_LOCK_WAIT
  } state_t;

  localparam logic [7:0] KEY_W = 8'h1a;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/piece_move_sched_if.sv
// Command/response handshake between the move sequencer and the piece datapath.
interface piece_move_sched_if;
  import piece_move_sched_pkg::*;

  logic cmd_valid;
  cmd_t cmd;
  logic cmd_ready;
  logic rsp_valid;
  logic rsp_blocked;

  modport master (output cmd_valid, cmd, input cmd_ready, rsp_valid, rsp_blocked);
  modport slave  (input cmd_valid, cmd, output cmd_ready, rsp_valid, rsp_blocked);
endinterface

// File: rtl/piece_move_sched_frame_tick_sync.sv
// Brings the asynchronous frame clock into the Clk domain and emits one tick per rising edge.
module piece_move_sched_frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);

  logic sync_p0, sync_p1, dly_p2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      dly_p2  <= 1'b0;
      tick    <= 1'b0;
    end else begin
      sync_p0 <= frame_clk;
      sync_p1 <= sync_p0;
      dly_p2  <= sync_p1;
      tick    <= sync_p1 & ~dly_p2;
    end
  end

endmodule

// File: rtl/piece_move_sched.sv
// Turns frame ticks and keycodes into one LEFT/RIGHT/DOWN/ROT/LOCK command at a time,
// waiting for the datapath's collision response before issuing the next.
module piece_move_sched
  import piece_move_sched_pkg::*;
#(
  parameter int GRAVITY_FRAMES = 16,
  parameter int SOFT_FRAMES    = 2,
  parameter int DAS_FRAMES     = 10,
  parameter int ARR_FRAMES     = 3
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_clk,
  input  logic                 enable,
  input  logic [7:0]           keycode,
  piece_move_sched_if.master   bus,
  output logic                 piece_locked,
  output logic                 busy
);

  localparam logic [5:0] GRAV_M1 = 6'(GRAVITY_FRAMES - 1);
  localparam logic [5:0] SOFT_M1 = 6'(SOFT_FRAMES - 1);
  localparam logic [5:0] DAS     = 6'(DAS_FRAMES);
  localparam logic [6:0] DAS_ARR = 7'(DAS_FRAMES + ARR_FRAMES);

  logic       tick;
  state_t     state;
  logic [5:0] grav_cnt, das_cnt, das_inc, grav_lim;
  logic [7:0] key_prev;
  logic       rot_pend, horz_pend, grav_pend;
  cmd_t       horz_dir;
  logic       tick_en, is_horz, new_key, grav_fire, rot_fire, horz_fire;
  logic       issue_done, lock_done;

  piece_move_sched_frame_tick_sync u_sync (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  assign tick_en    = tick & enable;
  assign is_horz    = (keycode == KEY_A) || (keycode == KEY_D);
  assign new_key    = (keycode != key_prev);
  assign grav_lim   = (keycode == KEY_S) ? SOFT_M1 : GRAV_M1;
  assign das_inc    = sat_inc6(das_cnt);
  assign grav_fire  = (grav_cnt >= grav_lim);
  assign rot_fire   = (keycode == KEY_W) && new_key;
  // After DAS expires, das_cnt is folded back to DAS on each repeat so it paces ARR forever.
  assign horz_fire  = is_horz && (new_key || (das_inc == DAS) || ({1'b0, das_inc} == DAS_ARR));
  assign issue_done = (state == S_ISSUE) && bus.cmd_valid && bus.cmd_ready;
  assign lock_done  = (state == S_LOCK_WAIT) && bus.rsp_valid;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      grav_cnt  <= '0;
      das_cnt   <= '0;
      key_prev  <= '0;
      rot_pend  <= 1'b0;
      horz_pend <= 1'b0;
      grav_pend <= 1'b0;
      horz_dir  <= CMD_LEFT;
    end else if (lock_done) begin
      grav_cnt  <= '0;
      das_cnt   <= '0;
      key_prev  <= keycode;
      rot_pend  <= 1'b0;
      horz_pend <= 1'b0;
      grav_pend <= 1'b0;
    end else begin
      // Clears come first so a tick landing on the same cycle as a transfer still sets its flag.
      if (issue_done) begin
        if (bus.cmd == CMD_ROT) rot_pend <= 1'b0;
        if (bus.cmd == CMD_LEFT || bus.cmd == CMD_RIGHT) horz_pend <= 1'b0;
        if (bus.cmd == CMD_DOWN) grav_pend <= 1'b0;
      end
      if (state == S_IDLE && !enable) begin
        rot_pend  <= 1'b0;
        horz_pend <= 1'b0;
        grav_pend <= 1'b0;
      end
      if (tick_en) begin
        key_prev <= keycode;
        grav_cnt <= grav_fire ? 6'd0 : grav_cnt + 6'd1;
        if (grav_fire) grav_pend <= 1'b1;
        if (rot_fire)  rot_pend  <= 1'b1;
        if (is_horz) begin
          if (new_key)                        das_cnt <= 6'd0;
          else if ({1'b0, das_inc} == DAS_ARR) das_cnt <= DAS;
          else                                das_cnt <= das_inc;
        end
        if (horz_fire) begin
          horz_pend <= 1'b1;
          horz_dir  <= (keycode == KEY_A) ? CMD_LEFT : CMD_RIGHT;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= S_IDLE;
      bus.cmd_valid <= 1'b0;
      bus.cmd       <= CMD_NOP;
      piece_locked  <= 1'b0;
    end else begin
      piece_locked <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && (rot_pend || horz_pend || grav_pend)) begin
            bus.cmd       <= rot_pend ? CMD_ROT : (horz_pend ? horz_dir : CMD_DOWN);
            bus.cmd_valid <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.cmd_ready) begin
            bus.cmd_valid <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.rsp_valid) begin
            if (bus.cmd == CMD_DOWN && bus.rsp_blocked) begin
              bus.cmd       <= CMD_LOCK;
              bus.cmd_valid <= 1'b1;
              state         <= S_LOCK_ISSUE;
            end else begin
              bus.cmd <= CMD_NOP;
              state   <= S_IDLE;
            end
          end
        end
        S_LOCK_ISSUE: begin
          if (bus.cmd_ready) begin
            bus.cmd_valid <= 1'b0;
            state         <= S_LOCK_WAIT;
          end
        end
        S_LOCK_WAIT: begin
          if (bus.rsp_valid) begin
            piece_locked <= 1'b1;
            bus.cmd      <= CMD_NOP;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_move_sched.sv
// Bench for piece_move_sched: directed tick table, hand-driven handshake corners, random ticks vs model.
module tb_piece_move_sched;
  import piece_move_sched_pkg::*;

  localparam int GRAV = 16, SOFT = 2, DAS = 10, ARR = 3;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic       enable;
  logic [7:0] keycode;
  logic       piece_locked, busy;

  piece_move_sched_if bus ();

  piece_move_sched #(
    .GRAVITY_FRAMES (GRAV),
    .SOFT_FRAMES    (SOFT),
    .DAS_FRAMES     (DAS),
    .ARR_FRAMES     (ARR)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .enable       (enable),
    .keycode      (keycode),
    .bus          (bus),
    .piece_locked (piece_locked),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  // Datapath side: automatic responder or hand-driven values.
  bit   auto_mode = 1'b1;
  bit   blk_down  = 1'b0;
  logic a_ready = 1'b0, a_rsp = 1'b0, a_blk = 1'b0;
  logic m_ready = 1'b0, m_rsp = 1'b0, m_blk = 1'b0;
  assign bus.cmd_ready   = auto_mode ? a_ready : m_ready;
  assign bus.rsp_valid   = auto_mode ? a_rsp   : m_rsp;
  assign bus.rsp_blocked = auto_mode ? a_blk   : m_blk;

  cmd_t got_q[$];
  int   lock_cnt = 0;
  int   hold_err = 0;
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    bit   prev_stall;
    cmd_t prev_cmd;
    cmd_t last;
    int   dly;
    prev_stall = 1'b0; prev_cmd = CMD_NOP; last = CMD_NOP; dly = -1;
    forever begin
      @(negedge Clk);
      if (piece_locked) lock_cnt++;
      if (!auto_mode || !Reset_n) begin
        prev_stall = 1'b0; dly = -1;
        a_rsp = 1'b0; a_blk = 1'b0; a_ready = 1'b0;
      end else begin
        if (prev_stall && !(bus.cmd_valid && bus.cmd == prev_cmd)) hold_err++;
        a_rsp = 1'b0; a_blk = 1'b0;
        if (dly == 0) begin
          a_rsp = 1'b1;
          a_blk = (last == CMD_DOWN) && blk_down;
          dly   = -1;
        end else if (dly > 0) dly--;
        a_ready    = ($urandom_range(3, 0) != 0);
        prev_stall = bus.cmd_valid && !a_ready;
        prev_cmd   = bus.cmd;
        if (bus.cmd_valid && a_ready) begin
          got_q.push_back(bus.cmd);
          last = bus.cmd;
          dly  = int'($urandom_range(2, 0));
        end
      end
    end
  end

  // Reference model state: frames since last DOWN, frames a horizontal key has been held.
  int         m_g, m_h;
  logic [7:0] m_kp;

  task automatic model_tick(input logic [7:0] k, input bit en, input bit blk,
                            output logic [14:0] exp, output int lk);
    int  n, lim;
    bit  rot, hz, gr;
    exp = '0; lk = 0; n = 0;
    if (en) begin
      lim = (k == KEY_S) ? SOFT : GRAV;
      gr  = (m_g >= lim - 1);
      m_g = gr ? 0 : m_g + 1;
      rot = (k == KEY_W) && (k != m_kp);
      hz  = 1'b0;
      if (k == KEY_A || k == KEY_D) begin
        if (k != m_kp) begin hz = 1'b1; m_h = 0; end
        else begin
          m_h++;
          hz = (m_h == DAS) || (m_h > DAS && (m_h - DAS) % ARR == 0);
        end
      end
      m_kp = k;
      if (rot) begin exp |= 15'(CMD_ROT) << (3 * n); n++; end
      if (hz)  begin exp |= 15'((k == KEY_A) ? CMD_LEFT : CMD_RIGHT) << (3 * n); n++; end
      if (gr) begin
        exp |= 15'(CMD_DOWN) << (3 * n); n++;
        if (blk) begin
          exp |= 15'(CMD_LOCK) << (3 * n); n++;
          lk = 1; m_g = 0; m_h = 0;
        end
      end
    end
  endtask

  function automatic logic [14:0] pack_from(input int s);
    logic [14:0] p = '0;
    for (int j = s; j < got_q.size() && j < s + 5; j++) p |= 15'(got_q[j]) << (3 * (j - s));
    return p;
  endfunction

  task automatic do_tick(input logic [7:0] k, input bit en, input bit blk);
    keycode = k; enable = en; blk_down = blk;
    @(negedge Clk); frame_clk = 1'b1;
    repeat (40) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (40) @(negedge Clk);
  endtask

  task automatic run_tick(input logic [7:0] k, input bit en, input bit blk,
                          input logic [14:0] exp, input int lk, input string nm);
    int s, l0;
    s = got_q.size(); l0 = lock_cnt;
    do_tick(k, en, blk);
    chk({nm, " cmds"}, 32'(pack_from(s)), 32'(exp));
    chk({nm, " locks"}, lock_cnt - l0, lk);
  endtask

  task automatic reset_dut();
    frame_clk = 1'b0; keycode = '0; enable = 1'b0; auto_mode = 1'b1;
    m_ready = 1'b0; m_rsp = 1'b0; m_blk = 1'b0;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset state", {28'd0, bus.cmd_valid, bus.cmd, busy, piece_locked}, 32'd0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    m_g = 0; m_h = 0; m_kp = '0;
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge Clk);
      found = bus.cmd_valid;
    end
  endtask

  typedef struct {
    logic [7:0]  key;
    bit          en;
    bit          blk;
    int          n;
    logic [14:0] exp;
    int          lk;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [7:0]  keys[6];
    logic [7:0]  k;
    logic [14:0] exp;
    bit          en, blk, found;
    int          lk;

    // exp lists commands first-in at the low 3 bits: 1 LEFT, 2 RIGHT, 3 DOWN, 4 ROT, 5 LOCK.
    tbl.push_back(vec_t'{8'h00, 1, 0, 15, 15'h000, 0});
    tbl.push_back(vec_t'{8'h00, 1, 0,  1, 15'h003, 0});
    tbl.push_back(vec_t'{8'h00, 1, 0, 15, 15'h000, 0});
    tbl.push_back(vec_t'{8'h00, 1, 0,  1, 15'h003, 0});
    tbl.push_back(vec_t'{KEY_A, 1, 0,  1, 15'h001, 0});
    tbl.push_back(vec_t'{KEY_A, 1, 0,  9, 15'h000, 0});
    tbl.push_back(vec_t'{KEY_A, 1, 0,  1, 15'h001, 0});
    tbl.push_back(vec_t'{KEY_A, 1, 0,  2, 15'h000, 0});
    tbl.push_back(vec_t'{KEY_A, 1, 0,  1, 15'h001, 0});
    tbl.push_back(vec_t'{KEY_A, 1, 0,  1, 15'h000, 0});
    tbl.push_back(vec_t'{KEY_A, 1, 0,  1, 15'h003, 0});
    tbl.push_back(vec_t'{KEY_A, 1, 0,  1, 15'h001, 0});
    tbl.push_back(vec_t'{KEY_W, 1, 0,  1, 15'h004, 0});
    tbl.push_back(vec_t'{KEY_W, 1, 0, 13, 15'h000, 0});
    tbl.push_back(vec_t'{KEY_W, 1, 0,  1, 15'h003, 0});
    tbl.push_back(vec_t'{KEY_W, 1, 0, 15, 15'h000, 0});
    tbl.push_back(vec_t'{8'h00, 1, 1,  1, 15'h02b, 1});
    tbl.push_back(vec_t'{8'h00, 1, 0, 15, 15'h000, 0});
    tbl.push_back(vec_t'{8'h00, 1, 0,  1, 15'h003, 0});
    tbl.push_back(vec_t'{8'h00, 1, 0, 15, 15'h000, 0});
    tbl.push_back(vec_t'{KEY_W, 1, 0,  1, 15'h01c, 0});
    tbl.push_back(vec_t'{KEY_S, 1, 0,  1, 15'h000, 0});
    tbl.push_back(vec_t'{KEY_S, 1, 0,  1, 15'h003, 0});
    tbl.push_back(vec_t'{KEY_S, 1, 0,  1, 15'h000, 0});
    tbl.push_back(vec_t'{KEY_S, 1, 0,  1, 15'h003, 0});
    tbl.push_back(vec_t'{KEY_D, 1, 0,  1, 15'h002, 0});
    tbl.push_back(vec_t'{KEY_D, 0, 0, 20, 15'h000, 0});
    tbl.push_back(vec_t'{KEY_D, 1, 0,  1, 15'h000, 0});
    tbl.push_back(vec_t'{KEY_A, 1, 0,  1, 15'h001, 0});
    tbl.push_back(vec_t'{KEY_D, 1, 0,  1, 15'h002, 0});

    Reset_n = 1'b1; frame_clk = 1'b0; keycode = '0; enable = 1'b0;
    #2;
    reset_dut();

    foreach (tbl[r])
      for (int j = 0; j < tbl[r].n; j++)
        run_tick(tbl[r].key, tbl[r].en, tbl[r].blk,
                 (j == tbl[r].n - 1) ? tbl[r].exp : 15'h000,
                 (j == tbl[r].n - 1) ? tbl[r].lk : 0,
                 $sformatf("row%0d.%0d", r, j));

    // ROT held off by cmd_ready low for 5 cycles, then answered blocked and dropped.
    reset_dut();
    auto_mode = 1'b0; enable = 1'b1; keycode = KEY_W;
    lk = lock_cnt;
    @(negedge Clk); frame_clk = 1'b1;
    wait_valid(found);
    chk("stall valid seen", 32'(found), 32'd1);
    chk("stall cmd", 32'(bus.cmd), 32'(CMD_ROT));
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk($sformatf("stall hold %0d", i), {28'd0, bus.cmd_valid, bus.cmd}, {28'd0, 1'b1, CMD_ROT});
    end
    m_ready = 1'b1;
    @(negedge Clk); m_ready = 1'b0;
    chk("after xfer valid/busy", {30'd0, bus.cmd_valid, busy}, 32'b01);
    m_rsp = 1'b1; m_blk = 1'b1;
    @(negedge Clk); m_rsp = 1'b0; m_blk = 1'b0;
    @(negedge Clk);
    chk("blocked rot dropped", {30'd0, bus.cmd_valid, busy}, 32'd0);
    chk("no lock after rot", lock_cnt - lk, 0);

    // A stray response while idle must not start anything.
    m_rsp = 1'b1; m_blk = 1'b1;
    @(negedge Clk); m_rsp = 1'b0; m_blk = 1'b0;
    repeat (3) @(negedge Clk);
    chk("stray rsp ignored", {30'd0, bus.cmd_valid, busy}, 32'd0);
    frame_clk = 1'b0;
    repeat (10) @(negedge Clk);

    // Reset asserted between clock edges while waiting for a response.
    keycode = KEY_D;
    frame_clk = 1'b1;
    wait_valid(found);
    chk("right valid seen", 32'(found), 32'd1);
    chk("right cmd", 32'(bus.cmd), 32'(CMD_RIGHT));
    m_ready = 1'b1;
    @(negedge Clk); m_ready = 1'b0;
    chk("in wait busy", {30'd0, bus.cmd_valid, busy}, 32'b01);
    #2 Reset_n = 1'b0;
    #1 chk("async reset", {28'd0, bus.cmd_valid, bus.cmd, busy}, 32'd0);
    frame_clk = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;

    // Random keys, pauses and blocked drops against the model.
    reset_dut();
    keys = '{8'h00, KEY_W, KEY_A, KEY_S, KEY_D, 8'h2c};
    k = 8'h00;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(6, 0) == 0) k = keys[$urandom_range(5, 0)];
      en  = ($urandom_range(9, 0) != 0);
      blk = ($urandom_range(9, 0) < 3);
      model_tick(k, en, blk, exp, lk);
      run_tick(k, en, blk, exp, lk, $sformatf("rand%0d", i));
    end

    chk("handshake hold errors", hold_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
